char_stream_upper: RTL and testbench

- Streaming front-end for the ASCII case-conversion datapath: accepts a byte stream over a valid/ready handshake and converts lowercase letters to uppercase.
- Buffers the converted bytes in a small FIFO and emits them over a valid/ready handshake.
- Frames the stream into strings delimited by a terminator byte and reports per-string statistics.
- Sits between the byte source (UART RX / test driver) and the downstream consumer.

---
 rtl/char_stream_upper.sv | 101 ++++++++++
 tb/tb_char_stream_upper.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/char_stream_upper.sv
// Byte-stream front end: uppercases ASCII letters on the way into a small FIFO
// and reports length/conversion statistics for each terminator-delimited string.
module char_stream_upper #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             str_done,
  output logic [CNT_W-1:0] str_len,
  output logic [CNT_W-1:0] str_conv
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [8:0]        mem [DEPTH];
  logic [8:0]        head;
  logic              full, empty, push, pop;
  logic              is_lower, is_term;
  logic [7:0]        conv_byte;
  logic [0:0]        state;
  logic [CNT_W-1:0]  len_cnt, conv_cnt;
  logic [CNT_W-1:0]  len_base, conv_base, len_next, conv_next;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready  = ~full & ~rst;
  assign push      = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  assign is_lower  = (in_data >= 8'h61) && (in_data <= 8'h7A);
  assign is_term   = (in_data == 8'h00) || (in_data == 8'h0A);
  assign conv_byte = is_lower ? (in_data & 8'hDF) : in_data;

  // Head is masked while empty so stale storage never leaks onto the outputs
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_data  = empty ? 8'h00 : head[7:0];
  assign out_last  = ~empty & head[8];

  // A fresh string always counts from zero, whatever the counters hold
  assign len_base  = (state == IDLE) ? '0 : len_cnt;
  assign conv_base = (state == IDLE) ? '0 : conv_cnt;
  assign len_next  = (len_base == CNT_MAX) ? len_base : len_base + CNT_W'(1);
  assign conv_next = (is_lower && (conv_base != CNT_MAX)) ? conv_base + CNT_W'(1) : conv_base;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {is_term, conv_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_cnt  <= '0;
      conv_cnt <= '0;
      str_done <= 1'b0;
      str_len  <= '0;
      str_conv <= '0;
    end else begin
      str_done <= 1'b0;
      if (push) begin
        if (is_term) begin
          str_done <= 1'b1;
          str_len  <= len_next;
          str_conv <= conv_next;
          len_cnt  <= '0;
          conv_cnt <= '0;
          state    <= IDLE;
        end else begin
          len_cnt  <= len_next;
          conv_cnt <= conv_next;
          state    <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_char_stream_upper.sv
// Directed bench for char_stream_upper: vector table for conversion/framing,
// hand-written sequences for back-pressure, reset and counter saturation.
module tb_char_stream_upper;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, str_done;
  logic [7:0] in_data, out_data, str_len, str_conv;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_str_done;
  logic [7:0] s_in_data, s_out_data;
  logic [3:0] s_str_len, s_str_conv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  char_stream_upper #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .str_done(str_done), .str_len(str_len), .str_conv(str_conv)
  );

  char_stream_upper #(.DEPTH(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last),
    .str_done(s_str_done), .str_len(s_str_len), .str_conv(s_str_conv)
  );

  typedef struct packed {
    logic [7:0] in_byte;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_done;
    logic [7:0] exp_len;
    logic [7:0] exp_conv;
  } vec_t;

  vec_t vecs [17];
  logic [7:0] bp [5];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered at a falling edge; accepts one byte and checks it at the head one cycle later
  task automatic apply_stimulus(input vec_t v);
    in_valid = 1'b1;
    in_data  = v.in_byte;
    #1 check_output("in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_output("out_valid", {31'd0, out_valid}, 32'd1);
    check_output("out_data", {24'd0, out_data}, {24'd0, v.exp_data});
    check_output("out_last", {31'd0, out_last}, {31'd0, v.exp_last});
    check_output("str_done", {31'd0, str_done}, {31'd0, v.exp_done});
    if (v.exp_done) begin
      check_output("str_len", {24'd0, str_len}, {24'd0, v.exp_len});
      check_output("str_conv", {24'd0, str_conv}, {24'd0, v.exp_conv});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{8'h61, 8'h41, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{8'h62, 8'h42, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{8'h31, 8'h31, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[3]  = '{8'h5A, 8'h5A, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[4]  = '{8'h0A, 8'h0A, 1'b1, 1'b1, 8'd5, 8'd2};
    vecs[5]  = '{8'h60, 8'h60, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[6]  = '{8'h61, 8'h41, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[7]  = '{8'h7A, 8'h5A, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[8]  = '{8'h7B, 8'h7B, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[9]  = '{8'h40, 8'h40, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[10] = '{8'hE1, 8'hE1, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[11] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'd7, 8'd2};
    vecs[12] = '{8'h0A, 8'h0A, 1'b1, 1'b1, 8'd1, 8'd0};
    vecs[13] = '{8'h0A, 8'h0A, 1'b1, 1'b1, 8'd1, 8'd0};
    vecs[14] = '{8'h78, 8'h58, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[15] = '{8'h79, 8'h59, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[16] = '{8'h0A, 8'h0A, 1'b1, 1'b1, 8'd3, 8'd2};
    bp[0] = 8'h11; bp[1] = 8'h12; bp[2] = 8'h13; bp[3] = 8'h14; bp[4] = 8'h15;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_out_data", {24'd0, out_data}, 32'd0);
    check_output("rst_out_last", {31'd0, out_last}, 32'd0);
    check_output("rst_str_done", {31'd0, str_done}, 32'd0);
    check_output("rst_str_len", {24'd0, str_len}, 32'd0);
    check_output("rst_str_conv", {24'd0, str_conv}, 32'd0);
    rst = 1'b0;
    #1 check_output("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 14; i++) apply_stimulus(vecs[i]);
    in_valid = 1'b0;
    @(negedge clk);
    check_output("drained_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("drained_str_done", {31'd0, str_done}, 32'd0);
    check_output("str_len_hold", {24'd0, str_len}, 32'd1);

    // Back-pressure: fill the FIFO, stall, then drain with no loss
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = bp[k];
      @(posedge clk);
      @(negedge clk);
      check_output("stall_out_data", {24'd0, out_data}, {24'd0, bp[0]});
      check_output("fill_in_ready", {31'd0, in_ready}, (k < 3) ? 32'd1 : 32'd0);
    end
    in_data = bp[4];
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("full_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("full_out_data", {24'd0, out_data}, {24'd0, bp[0]});
    end
    out_ready = 1'b1;
    #1 check_output("no_bypass_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 1; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("drain_out_data", {24'd0, out_data}, {24'd0, bp[k]});
      if (k == 1) check_output("drain_in_ready", {31'd0, in_ready}, 32'd1);
      if (k == 2) in_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_output("bp_empty", {31'd0, out_valid}, 32'd0);
    check_output("bp_str_done", {31'd0, str_done}, 32'd0);

    // Reset mid-string with three bytes buffered
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h61 + 8'(k);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_output("buffered_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1 check_output("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("mid_rst_str_done", {31'd0, str_done}, 32'd0);
    check_output("mid_rst_str_len", {24'd0, str_len}, 32'd0);
    out_ready = 1'b1;
    for (int i = 14; i < 17; i++) apply_stimulus(vecs[i]);
    in_valid = 1'b0;

    // Saturation on the narrow-counter instance
    for (int k = 0; k < 20; k++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'h61;
      @(posedge clk);
      @(negedge clk);
      check_output("sat_out_data", {24'd0, s_out_data}, 32'h41);
      check_output("sat_str_done", {31'd0, s_str_done}, 32'd0);
    end
    s_in_data = 8'h0A;
    @(posedge clk);
    @(negedge clk);
    check_output("sat_done", {31'd0, s_str_done}, 32'd1);
    check_output("sat_len", {28'd0, s_str_len}, 32'd15);
    check_output("sat_conv", {28'd0, s_str_conv}, 32'd15);
    s_in_data = 8'h62;
    @(posedge clk);
    @(negedge clk);
    s_in_data = 8'h0A;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    check_output("sat_next_done", {31'd0, s_str_done}, 32'd1);
    check_output("sat_next_len", {28'd0, s_str_len}, 32'd2);
    check_output("sat_next_conv", {28'd0, s_str_conv}, 32'd1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
